// File: rtl/prefix_pkg.sv
// rtl/prefix_pkg.sv - operation codes and elaboration helpers for the pipelined prefix adder
package prefix_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int pipe_lat(input int width, input int reg_every);
        return 1 + (clog2(width) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// rtl/prefix_gp_cell.sv - black cell merging a high and a low generate/propagate pair
module prefix_gp_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/pipe_prefix_adder.sv
// rtl/pipe_prefix_adder.sv - pipelined Kogge-Stone adder/subtractor with valid/ready and tag
module pipe_prefix_adder
    import prefix_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int GROUPS = (LEVELS + REG_EVERY - 1) / REG_EVERY;
    localparam int LAST   = GROUPS - 1;

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
    logic [TAG_W-1:0] out_tag_d, out_tag_q;
    logic [WIDTH-1:0] carry;
    logic             unused_p;

    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;
    assign bx       = (op == OP_SUB) ? ~b : b;

    // Prefix position i covers operand bits below i; position 0 is the virtual bit carrying cin.
    for (genvar s = 0; s < GROUPS; s++) begin : stg
        logic             v_d, v_q;
        logic [TAG_W-1:0] tag_d, tag_q;
        logic [WIDTH-1:0] g_d, g_q, p_d, p_q, h_d, h_q;
        logic             gmsb_d, gmsb_q, amsb_d, amsb_q, bmsb_d, bmsb_q;

        if (s == 0) begin : src
            always_comb begin
                v_d    = v_q;
                tag_d  = tag_q;
                g_d    = g_q;
                p_d    = p_q;
                h_d    = h_q;
                gmsb_d = gmsb_q;
                amsb_d = amsb_q;
                bmsb_d = bmsb_q;
                if (adv) begin
                    v_d    = in_valid;
                    tag_d  = tag;
                    g_d    = {a[WIDTH-2:0] & bx[WIDTH-2:0], cin};
                    p_d    = {a[WIDTH-2:0] ^ bx[WIDTH-2:0], 1'b0};
                    h_d    = a ^ bx;
                    gmsb_d = a[WIDTH-1] & bx[WIDTH-1];
                    amsb_d = a[WIDTH-1];
                    bmsb_d = bx[WIDTH-1];
                end
            end
        end else begin : src
            always_comb begin
                v_d    = v_q;
                tag_d  = tag_q;
                g_d    = g_q;
                p_d    = p_q;
                h_d    = h_q;
                gmsb_d = gmsb_q;
                amsb_d = amsb_q;
                bmsb_d = bmsb_q;
                if (adv) begin
                    v_d    = stg[s-1].v_q;
                    tag_d  = stg[s-1].tag_q;
                    g_d    = lvl[s*REG_EVERY].g_out;
                    p_d    = lvl[s*REG_EVERY].p_out;
                    h_d    = stg[s-1].h_q;
                    gmsb_d = stg[s-1].gmsb_q;
                    amsb_d = stg[s-1].amsb_q;
                    bmsb_d = stg[s-1].bmsb_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                tag_q  <= '0;
                g_q    <= '0;
                p_q    <= '0;
                h_q    <= '0;
                gmsb_q <= 1'b0;
                amsb_q <= 1'b0;
                bmsb_q <= 1'b0;
            end else begin
                v_q    <= v_d;
                tag_q  <= tag_d;
                g_q    <= g_d;
                p_q    <= p_d;
                h_q    <= h_d;
                gmsb_q <= gmsb_d;
                amsb_q <= amsb_d;
                bmsb_q <= bmsb_d;
            end
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : lvl
        localparam int D = 1 << (k - 1);
        logic [WIDTH-1:0] g_in, p_in, g_out, p_out;

        if ((k - 1) % REG_EVERY == 0) begin : from_reg
            assign g_in = stg[(k-1)/REG_EVERY].g_q;
            assign p_in = stg[(k-1)/REG_EVERY].p_q;
        end else begin : from_comb
            assign g_in = lvl[k-1].g_out;
            assign p_in = lvl[k-1].p_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : col
            if (i >= D) begin : black
                prefix_gp_cell u_cell (
                    .g_hi (g_in[i]),
                    .p_hi (p_in[i]),
                    .g_lo (g_in[i-D]),
                    .p_lo (p_in[i-D]),
                    .g    (g_out[i]),
                    .p    (p_out[i])
                );
            end else begin : pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    assign carry    = lvl[LEVELS].g_out;
    assign unused_p = ^lvl[LEVELS].p_out;

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            out_valid_d = stg[LAST].v_q;
            sum_d       = stg[LAST].h_q ^ carry;
            cout_d      = stg[LAST].gmsb_q | (stg[LAST].h_q[WIDTH-1] & carry[WIDTH-1]);
            ovf_d       = (stg[LAST].amsb_q == stg[LAST].bmsb_q) &&
                          (sum_d[WIDTH-1] != stg[LAST].amsb_q);
            zero_d      = (sum_d == '0);
            out_tag_d   = stg[LAST].tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// tb/tb_pipe_prefix_adder.sv - scoreboard bench for pipe_prefix_adder over four width/depth configurations
module tb_pipe_prefix_adder;

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic [3:0]   tag;
        int           cyc;
        bit           lat_chk;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   done [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_cmp = 0;
        n_bad = 0;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar t = 0; t < 4; t++) begin : inst
        localparam int W    = (t == 0) ? 32 : (t == 1) ? 64 : (t == 2) ? 8 : 128;
        localparam int RE   = (t == 0) ? 1  : (t == 1) ? 2  : (t == 2) ? 3 : 7;
        localparam int LATX = (t == 0) ? 6  : (t == 1) ? 4  : 2;

        logic         rst_n, in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
        logic [W-1:0] a, b, sum;
        logic [3:0]   tag, out_tag;
        exp_t         q[$];

        pipe_prefix_adder #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(4)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .op        (op),
            .tag       (tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf),
            .zero      (zero),
            .out_tag   (out_tag)
        );

        // Reference: true integer arithmetic; signed overflow means the exact signed sum is unrepresentable.
        function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                       input logic mo, input logic [3:0] mt, input bit lchk);
            logic [W-1:0]          bxv;
            logic [W:0]            full;
            logic signed [W+1:0]   s, smax, smin;
            exp_t                  e;
            bxv  = mo ? ~mb : mb;
            full = {1'b0, ma} + {1'b0, bxv} + {{W{1'b0}}, mc};
            s    = $signed({ma[W-1], ma[W-1], ma}) + $signed({bxv[W-1], bxv[W-1], bxv})
                 + $signed({{(W+1){1'b0}}, mc});
            smax = $signed({3'b000, {(W-1){1'b1}}});
            smin = ~smax;
            e.sum          = '0;
            e.sum[W-1:0]   = full[W-1:0];
            e.cout         = full[W];
            e.ovf          = (s > smax) || (s < smin);
            e.zero         = (full[W-1:0] == '0);
            e.tag          = mt;
            e.cyc          = cyc;
            e.lat_chk      = lchk;
            return e;
        endfunction

        function automatic logic [W-1:0] rnd_op();
            logic [127:0] r;
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       r = '0;
                1:       r = '1;
                2:       r = 128'd1;
                3:       r = 128'd1 << (W - 1);
                default: ;
            endcase
            return r[W-1:0];
        endfunction

        task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                             input logic iop, input logic [3:0] itag, input bit lchk, input bit rnd_ready);
            int tries;
            bit acc;
            tries = 0;
            acc   = 1'b0;
            while (!acc) begin
                @(posedge clk);
                #1;
                a        = ia;
                b        = ib;
                cin      = icin;
                op       = iop;
                tag      = itag;
                in_valid = 1'b1;
                if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_ready) begin
                    q.push_back(model(ia, ib, icin, iop, itag, lchk));
                    acc = 1'b1;
                end else if (++tries > 100) begin
                    chk($sformatf("w%0d_accept_timeout", W), 128'(in_ready), 128'd1);
                    acc = 1'b1;
                end
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) chk($sformatf("w%0d_drain_timeout", W), 128'(q.size()), 128'd0);
            repeat (4) @(negedge clk);
        endtask

        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("w%0d_unexpected_out", W), 128'(out_valid), 128'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("w%0d_sum", W), 128'(sum), e.sum);
                        chk($sformatf("w%0d_cout", W), 128'(cout), 128'(e.cout));
                        chk($sformatf("w%0d_ovf", W), 128'(ovf), 128'(e.ovf));
                        chk($sformatf("w%0d_zero", W), 128'(zero), 128'(e.zero));
                        chk($sformatf("w%0d_tag", W), 128'(out_tag), 128'(e.tag));
                        if (e.lat_chk)
                            chk($sformatf("w%0d_latency", W), 128'(cyc - e.cyc), 128'(LATX));
                    end
                end
            end
        end

        if (t == 0) begin : dir
            initial begin
                logic [W-1:0] hs;
                logic [3:0]   ht;
                rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
                tag = '0; out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                chk("rst_in_ready", 128'(in_ready), 128'd1);
                chk("rst_out_valid", 128'(out_valid), 128'd0);
                chk("rst_sum", 128'(sum), 128'd0);
                chk("rst_flags", 128'({cout, ovf, zero}), 128'd0);
                chk("rst_out_tag", 128'(out_tag), 128'd0);

                issue(32'd1, 32'd2, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
                issue(32'd2, 32'd1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
                issue(32'd6, 32'd7, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
                drain();

                issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
                issue(32'd5, 32'd7, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
                issue(32'h8000_0000, 32'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
                drain();

                for (int k = 0; k < 6; k++)
                    issue(32'(k * 3 + 1), 32'(k + 5), 1'b0, 1'b0, 4'(k + 8), 1'b0, 1'b0);
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                hs = sum;
                ht = out_tag;
                chk("stall_valid", 128'(out_valid), 128'd1);
                chk("stall_in_ready", 128'(in_ready), 128'd0);
                chk("stall_head_sum", 128'(sum), q[0].sum);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 128'(in_ready), 128'd0);
                    chk("stall_sum_stable", 128'(sum), 128'(hs));
                    chk("stall_tag_stable", 128'(out_tag), 128'(ht));
                end
                drain();

                for (int k = 0; k < 3; k++)
                    issue(32'(100 + k), 32'(7 * k + 3), 1'b0, 1'b0, 4'(k + 1), 1'b0, 1'b0);
                @(posedge clk);
                #1;
                rst_n    = 1'b0;
                in_valid = 1'b0;
                q.delete();
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                chk("rst2_out_valid", 128'(out_valid), 128'd0);
                chk("rst2_sum", 128'(sum), 128'd0);
                chk("rst2_flags", 128'({cout, ovf, zero}), 128'd0);
                chk("rst2_out_tag", 128'(out_tag), 128'd0);
                chk("rst2_in_ready", 128'(in_ready), 128'd1);
                repeat (10) @(negedge clk);
                issue(32'd40, 32'd2, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
                drain();
                done[t] = 1'b1;
            end
        end else begin : rnd
            initial begin
                rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
                tag = '0; out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 4'($urandom), 1'b1, 1'b0);
                drain();
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                        in_valid  = 1'b0;
                        out_ready = ($urandom_range(0, 3) != 0);
                        @(negedge clk);
                    end
                    issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 4'($urandom), 1'b0, 1'b1);
                end
                drain();
                done[t] = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 80000; i++) begin
            @(posedge clk);
            if (done[0] && done[1] && done[2] && done[3]) break;
        end
        if (!(done[0] && done[1] && done[2] && done[3])) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: done=%0d%0d%0d%0d want 1111", done[0], done[1], done[2], done[3]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_prefix_adder.md
# pipe_prefix_adder

Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor with a valid/ready handshake on both sides. It replaces the fixed 16/32-bit pipelined prefix adder in the processor datapath with a block that is generic in width and pipeline depth. It adds a subtract mode, signed overflow and zero flags, a transaction tag, and back-pressure stalling. It sits in the ALU execute stage of the 64-bit core.

## Interface
- `WIDTH`, 64: operand width; power of two, 8..128.
- `REG_EVERY`, 1: prefix levels per pipeline register; 1..clog2(WIDTH).
- `TAG_W`, 4: width of the pass-through tag.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: block accepts the operand set this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry in.
- `op` input 1: 0 = add, 1 = subtract.
- `tag` input TAG_W: opaque ID, returned with the result.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB.
- `ovf` output 1: signed overflow.
- `zero` output 1: high when sum == 0.
- `out_tag` output TAG_W: tag of the result.

## Operation
- Effective B: `bx = op ? ~b : b`.
- Result: `{cout, sum} = a + bx + cin`, computed modulo 2^(WIDTH+1).
  - Subtract a−b requires cin=1. With op=1, cout=0 means borrow.
- `ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB])`.
- Pipeline structure:
  - Stage 1 registers the bitwise generate/propagate terms and a[MSB], bx[MSB].
  - L = clog2(WIDTH) prefix levels are split into ceil(L/REG_EVERY) groups. Each group ends in a register.
  - cin enters as the generate term of a virtual bit −1.
  - The last group also forms sum, cout, ovf and zero before its register.
  - Outputs come directly from that final register.
- Each stage holds a valid bit and the tag.
- Handshake:
  - Global stall: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - The pipeline advances when !stall. Bubbles advance too; they are not collapsed.
  - Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Ordering is strictly FIFO; results are never dropped or duplicated.
- Reset (rst_n low at a rising edge):
  - Clears every valid bit and every data/flag/tag register to 0.
  - Any in-flight operations are discarded.
  - in_ready is high during the first cycle after reset is released.

## Timing
- Latency LAT = 1 + ceil(clog2(WIDTH)/REG_EVERY) cycles.
  - Operands accepted in cycle c appear on the outputs in cycle c+LAT, when no stall occurs.
  - Examples: WIDTH=32, REG_EVERY=1 gives LAT=6. WIDTH=64, REG_EVERY=2 gives LAT=4. WIDTH=8, REG_EVERY=3 gives LAT=2.
- Throughput: one result per cycle while out_ready stays high.
- During a stall, every register holds its value. sum, flags and out_tag stay stable until the transfer.
- In a cycle where out_ready rises while the pipe is full, a new input is accepted in that same cycle (in_ready is combinational from out_ready).
- No combinational path runs from a/b/cin/op to any output.
- Reset outputs: out_valid=0, sum=0, cout=0, ovf=0, zero=0, out_tag=0.

## Structure
- Package `prefix_pkg` holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - Constant functions clog2 and pipe_lat(WIDTH, REG_EVERY).
- Sub-module `prefix_gp_cell` is the combinational black cell: (g_hi,p_hi,g_lo,p_lo) → (g,p).
  - It is instantiated by generate loops per level.
  - Pass-through of the previous (g,p) needs no cell.

## Test plan
- WIDTH=32, REG_EVERY=1, out_ready=1. Back-to-back inputs (1,2,cin1), (2,1,cin1), (6,7,cin1), add.
  - Required: sums 4, 4, 14 in three consecutive cycles, starting 6 cycles after the first input; tags returned in order.
- a=0xFFFFFFFF, b=1, cin=0, add.
  - Required: sum=0, cout=1, zero=1, ovf=0.
- Subtract, cin=1:
  - 5−7 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - 0x80000000−1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Full pipe, out_ready held low 3 cycles.
  - Required: in_ready=0 for those cycles; sum/out_tag stable.
  - After release, all 6 in-flight results emerge in order, with no loss or duplicates.
- rst_n low for one cycle with 3 operations in flight.
  - Required: next cycle out_valid=0 and all outputs 0.
  - No stale results appear afterwards; a new operation completes with the normal LAT.
- Parameter sweep (64/2, 8/3, 128/7) with random operands, op, cin and out_ready.
  - Check against a reference model; LAT equals 4, 2 and 2 respectively.
